// File: rtl/bram_fifo_pkg.sv
// rtl/bram_fifo_pkg.sv - geometry and types for the SB_RAM256x16 FIFO controller
package bram_fifo_pkg;
    localparam int RAM_AW    = 8;
    localparam int RAM_DW    = 16;
    localparam int RAM_DEPTH = 256;

    typedef logic [RAM_AW-1:0] ram_addr_t;
    typedef logic [RAM_DW-1:0] ram_word_t;
    typedef logic [RAM_AW:0]   fifo_cnt_t;

    localparam fifo_cnt_t MEM_FULL = fifo_cnt_t'(RAM_DEPTH);
    localparam fifo_cnt_t CAPACITY = fifo_cnt_t'(RAM_DEPTH + 2);
endpackage

// File: rtl/bram_fifo_out_stage.sv
// rtl/bram_fifo_out_stage.sv - 2-entry registered skid buffer fed by RAM read data
module bram_fifo_out_stage
    import bram_fifo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inflight,
    input  ram_word_t   ram_rdata,
    input  logic        rd_ready,
    output logic        rd_valid,
    output ram_word_t   rd_data,
    output logic [1:0]  occupancy
);
    logic      out_v_q, out_v_d;
    logic      skid_v_q, skid_v_d;
    ram_word_t out_data_q, out_data_d;
    ram_word_t skid_data_q, skid_data_d;
    logic      pop;

    always_comb begin
        pop         = out_v_q && rd_ready;
        out_v_d     = out_v_q;
        skid_v_d    = skid_v_q;
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;
        if (pop) begin
            // skid always holds the older word, so it refills out before fresh RAM data
            if (skid_v_q) begin
                out_data_d = skid_data_q;
                if (inflight) skid_data_d = ram_rdata;
                else          skid_v_d    = 1'b0;
            end else if (inflight) begin
                out_data_d = ram_rdata;
            end else begin
                out_v_d = 1'b0;
            end
        end else if (inflight) begin
            if (!out_v_q) begin
                out_v_d    = 1'b1;
                out_data_d = ram_rdata;
            end else begin
                skid_v_d    = 1'b1;
                skid_data_d = ram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            out_v_q     <= 1'b0;
            skid_v_q    <= 1'b0;
            out_data_q  <= '0;
            skid_data_q <= '0;
        end else begin
            out_v_q     <= out_v_d;
            skid_v_q    <= skid_v_d;
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign rd_valid  = out_v_q;
    assign rd_data   = out_data_q;
    assign occupancy = {1'b0, out_v_q} + {1'b0, skid_v_q};
endmodule

// File: rtl/bram_fifo_ctrl.sv
// rtl/bram_fifo_ctrl.sv - SB_RAM256x16 sequenced as a 258-word FIFO; level port under BRAM_FIFO_LEVEL_EN
module bram_fifo_ctrl
    import bram_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_valid,
    input  logic [RAM_DW-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [RAM_DW-1:0] rd_data,
    input  logic              rd_ready,
    output logic              ram_we,
    output logic              ram_wclke,
    output logic [RAM_AW-1:0] ram_waddr,
    output logic [RAM_DW-1:0] ram_wdata,
    output logic [RAM_DW-1:0] ram_mask,
    output logic              ram_re,
    output logic              ram_rclke,
    output logic [RAM_AW-1:0] ram_raddr,
    input  logic [RAM_DW-1:0] ram_rdata
`ifdef BRAM_FIFO_LEVEL_EN
    ,
    output logic [RAM_AW:0]   level
`endif
);
    ram_addr_t wptr_q, wptr_d;
    ram_addr_t rptr_q, rptr_d;
    fifo_cnt_t mem_cnt_q, mem_cnt_d;
    logic      inflight_q, inflight_d;
    logic      push, pop, issue, full, flush;
    logic [1:0] occupancy;
    logic [2:0] stage_used;

    bram_fifo_out_stage u_out_stage (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .inflight  (inflight_q),
        .ram_rdata (ram_rdata),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .occupancy (occupancy)
    );

    always_comb begin
        flush      = rst || clr;
        full       = (mem_cnt_q == MEM_FULL);
        wr_ready   = !rst && !full;
        push       = wr_valid && wr_ready && !clr;
        pop        = rd_valid && rd_ready;
        stage_used = {1'b0, occupancy} + {2'b00, inflight_q};
        // registered mem_cnt keeps a same-cycle push from being read back before it lands
        issue      = !flush && (mem_cnt_q != '0) && (stage_used < (3'd2 + {2'b00, pop}));

        wptr_d     = push  ? wptr_q + 8'd1 : wptr_q;
        rptr_d     = issue ? rptr_q + 8'd1 : rptr_q;
        mem_cnt_d  = mem_cnt_q + fifo_cnt_t'(push) - fifo_cnt_t'(issue);
        inflight_d = issue;

        ram_we     = push;
        ram_wclke  = push;
        ram_waddr  = wptr_q;
        ram_wdata  = wr_data;
        ram_mask   = '0;
        ram_re     = issue;
        ram_rclke  = issue;
        ram_raddr  = rptr_q;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            mem_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            mem_cnt_q  <= mem_cnt_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef BRAM_FIFO_LEVEL_EN
    logic [RAM_AW+1:0] level_sum;
    always_comb begin
        level_sum = {1'b0, mem_cnt_q} + {8'd0, occupancy} + {9'd0, inflight_q};
        level     = (level_sum > {1'b0, CAPACITY}) ? CAPACITY : level_sum[RAM_AW:0];
    end
`endif
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb/tb_bram_fifo_ctrl.sv - directed table plus scoreboard sequences for bram_fifo_ctrl
module tb_bram_fifo_ctrl;
    logic        clk = 1'b0;
    logic        rst, clr, wr_valid, rd_ready;
    logic [15:0] wr_data;
    logic        wr_ready, rd_valid;
    logic [15:0] rd_data;
    logic        ram_we, ram_wclke, ram_re, ram_rclke;
    logic [7:0]  ram_waddr, ram_raddr;
    logic [15:0] ram_wdata, ram_mask, ram_rdata;
`ifdef BRAM_FIFO_LEVEL_EN
    logic [8:0]  level;
`endif

    bram_fifo_ctrl dut (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .ram_we(ram_we), .ram_wclke(ram_wclke), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .ram_mask(ram_mask),
        .ram_re(ram_re), .ram_rclke(ram_rclke), .ram_raddr(ram_raddr),
        .ram_rdata(ram_rdata)
`ifdef BRAM_FIFO_LEVEL_EN
        , .level(level)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (ram_we && ram_wclke) mem[ram_waddr] <= ram_wdata;
        if (ram_re && ram_rclke) ram_rdata <= mem[ram_raddr];
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, wv;
        logic [15:0] wd;
        logic        rr;
        logic        e_wr_ready, e_rd_valid, chk_data;
        logic [15:0] e_rd_data;
        logic        e_we, e_re;
        logic [7:0]  e_addr;
    } vec_t;
    vec_t vt[14];

    logic [15:0] q[$];
    int          npush = 0, npop = 0, cyc = 0, first_pop = -1, last_pop = -1;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic        s_wr_ready, s_rd_valid, s_we, s_re;
    logic [7:0]  s_waddr, s_raddr;

    task automatic step(input logic c, input logic wv, input logic [15:0] wd, input logic rr);
        clr = c; wr_valid = wv; wr_data = wd; rd_ready = rr;
        @(negedge clk);
        s_wr_ready = wr_ready; s_rd_valid = rd_valid;
        s_we = ram_we; s_re = ram_re; s_waddr = ram_waddr; s_raddr = ram_raddr;
        check("ram_collision", {31'd0, ram_we && ram_re && (ram_waddr == ram_raddr)}, 0);
        if (prev_stall) begin
            check("stall_valid", {31'd0, rd_valid}, 1);
            check("stall_data", {16'd0, rd_data}, {16'd0, prev_data});
        end
        if (c) begin
            q.delete();
        end else begin
            if (rd_valid && rr) begin
                check("pop_nonempty", {31'd0, q.size() != 0}, 1);
                if (q.size() != 0) check("pop_order", {16'd0, rd_data}, {16'd0, q.pop_front()});
                npop++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            if (wv && wr_ready) begin
                q.push_back(wd);
                npush++;
            end
        end
        prev_stall = !c && rd_valid && !rr;
        prev_data  = rd_data;
        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //        rst wv  wd        rr  wrdy rv  chk data      we  re  addr
        vt[0]  = '{1, 0, 16'h0000, 0, 0,  0,  1, 16'h0000, 0,  0,  8'd0};
        vt[1]  = '{0, 0, 16'h0000, 0, 1,  0,  1, 16'h0000, 0,  0,  8'd0};
        vt[2]  = '{0, 1, 16'hA5A5, 1, 1,  0,  1, 16'h0000, 1,  0,  8'd0};
        vt[3]  = '{0, 0, 16'h0000, 1, 1,  0,  0, 16'h0000, 0,  1,  8'd0};
        vt[4]  = '{0, 0, 16'h0000, 1, 1,  0,  0, 16'h0000, 0,  0,  8'd1};
        vt[5]  = '{0, 0, 16'h0000, 1, 1,  1,  1, 16'hA5A5, 0,  0,  8'd1};
        vt[6]  = '{0, 0, 16'h0000, 0, 1,  0,  0, 16'h0000, 0,  0,  8'd1};
        vt[7]  = '{0, 1, 16'h1234, 0, 1,  0,  0, 16'h0000, 1,  0,  8'd1};
        vt[8]  = '{0, 0, 16'h0000, 0, 1,  0,  0, 16'h0000, 0,  1,  8'd1};
        vt[9]  = '{0, 0, 16'h0000, 0, 1,  0,  0, 16'h0000, 0,  0,  8'd2};
        vt[10] = '{0, 0, 16'h0000, 0, 1,  1,  1, 16'h1234, 0,  0,  8'd2};
        vt[11] = '{0, 0, 16'h0000, 0, 1,  1,  1, 16'h1234, 0,  0,  8'd2};
        vt[12] = '{0, 0, 16'h0000, 1, 1,  1,  1, 16'h1234, 0,  0,  8'd2};
        vt[13] = '{0, 0, 16'h0000, 0, 1,  0,  0, 16'h0000, 0,  0,  8'd2};

        rst = 1; clr = 0; wr_valid = 0; wr_data = 0; rd_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 14; i++) begin
            rst = vt[i].rst; wr_valid = vt[i].wv; wr_data = vt[i].wd; rd_ready = vt[i].rr;
            @(negedge clk);
            check($sformatf("v%0d_wr_ready", i), {31'd0, wr_ready}, {31'd0, vt[i].e_wr_ready});
            check($sformatf("v%0d_rd_valid", i), {31'd0, rd_valid}, {31'd0, vt[i].e_rd_valid});
            if (vt[i].chk_data) check($sformatf("v%0d_rd_data", i), {16'd0, rd_data}, {16'd0, vt[i].e_rd_data});
            check($sformatf("v%0d_ram_we", i), {31'd0, ram_we && ram_wclke}, {31'd0, vt[i].e_we});
            check($sformatf("v%0d_ram_re", i), {31'd0, ram_re && ram_rclke}, {31'd0, vt[i].e_re});
            check($sformatf("v%0d_ram_mask", i), {16'd0, ram_mask}, 0);
            if (vt[i].e_we || !vt[i].e_re) check($sformatf("v%0d_waddr", i), {24'd0, ram_waddr}, {24'd0, vt[i].e_addr});
            if (vt[i].e_re || !vt[i].e_we) check($sformatf("v%0d_raddr", i), {24'd0, ram_raddr}, {24'd0, vt[i].e_addr});
            if (vt[i].e_we) check($sformatf("v%0d_wdata", i), {16'd0, ram_wdata}, {16'd0, vt[i].wd});
            @(posedge clk); #1;
        end
        rst = 0;

        // fill with the consumer stalled: 258 accepts, then full
        for (int i = 0; i < 300; i++) begin
            step(0, 1, 16'(i), 0);
            if (!s_wr_ready) break;
        end
        check("fill_accepts", q.size(), 258);
        step(0, 1, 16'hFFFF, 0);
        check("full_hold", {31'd0, s_wr_ready}, 0);
`ifdef BRAM_FIFO_LEVEL_EN
        check("level_full", {23'd0, level}, 258);
`endif
        step(0, 1, 16'd258, 1);
        check("full_push_pop_ready", {31'd0, s_wr_ready}, 0);
        step(0, 1, 16'd258, 0);
        check("ready_after_pop", {31'd0, s_wr_ready}, 1);
        for (int i = 0; i < 400 && q.size() != 0; i++) step(0, 0, 16'h0, 1);
        repeat (3) step(0, 0, 16'h0, 1);
        check("drain_empty", q.size(), 0);
        check("drain_rd_valid", {31'd0, s_rd_valid}, 0);
        check("drain_wr_ready", {31'd0, s_wr_ready}, 1);

        // sustained streaming across pointer wraps
        npush = 0; npop = 0; first_pop = -1; last_pop = -1;
        for (int i = 0; i < 600; i++) step(0, 1, 16'(1000 + i), 1);
        for (int i = 0; i < 20 && q.size() != 0; i++) step(0, 0, 16'h0, 1);
        check("stream_pushes", npush, 600);
        check("stream_pops", npop, 600);
        check("stream_rate", last_pop - first_pop, 599);

        // flush while a word is presented and another is in flight
        step(0, 1, 16'h0050, 0);
        step(0, 1, 16'h0051, 0);
        step(0, 1, 16'h0052, 0);
        check("clr_pre_re", {31'd0, s_re}, 1);
        step(1, 1, 16'h0053, 1);
        check("clr_pre_valid", {31'd0, s_rd_valid}, 1);
        step(0, 0, 16'h0, 1);
        check("clr_rd_valid", {31'd0, s_rd_valid}, 0);
        check("clr_wr_ready", {31'd0, s_wr_ready}, 1);
`ifdef BRAM_FIFO_LEVEL_EN
        check("clr_level", {23'd0, level}, 0);
`endif
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 16'h0, 1);
            check("clr_no_stale", {31'd0, s_rd_valid}, 0);
        end
        step(0, 1, 16'hBEEF, 1);
        check("clr_waddr", {24'd0, s_waddr}, 0);
        step(0, 0, 16'h0, 1);
        check("clr_re", {31'd0, s_re}, 1);
        check("clr_raddr", {24'd0, s_raddr}, 0);
        npop = 0;
        for (int i = 0; i < 10; i++) step(0, 0, 16'h0, 1);
        check("clr_one_pop", npop, 1);
        check("clr_empty", q.size(), 0);

        // random backpressure over 1000 words
        npush = 0; npop = 0;
        for (int i = 0; i < 8000 && npop < 1000; i++) begin
            step(0, (npush < 1000) && ($urandom_range(0, 3) != 0),
                 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
        end
        check("rand_pushes", npush, 1000);
        check("rand_pops", npop, 1000);
        check("rand_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
